// File: rtl/pe_frame_sequencer_if.sv
// rtl/pe_frame_sequencer_if.sv - pe Start/Ack handshake and pixel data bundle
// master = frame sequencer (initiator), slave = pe instance.
interface pe_frame_sequencer_if;
  logic       pe_start_sum;
  logic       pe_start_bg;
  logic       pe_ack;
  logic [7:0] pe_threshold;
  logic [7:0] pe_desired_bg_r;
  logic [7:0] pe_desired_bg_g;
  logic [7:0] pe_desired_bg_b;
  logic [7:0] pe_red_in;
  logic [7:0] pe_green_in;
  logic [7:0] pe_blue_in;
  logic [7:0] pe_red_exp;
  logic [7:0] pe_green_exp;
  logic [7:0] pe_blue_exp;
  logic       pe_sum_done;
  logic       pe_bg_done;
  logic [7:0] pe_red_sum;
  logic [7:0] pe_green_sum;
  logic [7:0] pe_blue_sum;
  logic [7:0] pe_red_out;
  logic [7:0] pe_green_out;
  logic [7:0] pe_blue_out;

  modport master (
    output pe_start_sum, pe_start_bg, pe_ack,
    output pe_threshold, pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b,
    output pe_red_in, pe_green_in, pe_blue_in,
    output pe_red_exp, pe_green_exp, pe_blue_exp,
    input  pe_sum_done, pe_bg_done,
    input  pe_red_sum, pe_green_sum, pe_blue_sum,
    input  pe_red_out, pe_green_out, pe_blue_out
  );

  modport slave (
    input  pe_start_sum, pe_start_bg, pe_ack,
    input  pe_threshold, pe_desired_bg_r, pe_desired_bg_g, pe_desired_bg_b,
    input  pe_red_in, pe_green_in, pe_blue_in,
    input  pe_red_exp, pe_green_exp, pe_blue_exp,
    output pe_sum_done, pe_bg_done,
    output pe_red_sum, pe_green_sum, pe_blue_sum,
    output pe_red_out, pe_green_out, pe_blue_out
  );
endinterface

// File: rtl/pe_frame_sequencer.sv
// rtl/pe_frame_sequencer.sv - two-pass (sum, background removal) frame sequencer for one pe
// Pass 1 accumulates per-channel sums to form the mean; pass 2 removes background and writes back.
module pe_frame_sequencer #(
  parameter int LOG2_PIXELS = 2,
  parameter int WAIT_LIMIT  = 255
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [7:0]             threshold,
  input  logic [7:0]             desired_bg_r,
  input  logic [7:0]             desired_bg_g,
  input  logic [7:0]             desired_bg_b,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [LOG2_PIXELS-1:0] pix_addr,
  input  logic [7:0]             pix_r,
  input  logic [7:0]             pix_g,
  input  logic [7:0]             pix_b,
  output logic                   out_we,
  output logic [LOG2_PIXELS-1:0] out_addr,
  output logic [7:0]             out_r,
  output logic [7:0]             out_g,
  output logic [7:0]             out_b,
  pe_frame_sequencer_if.master   pe
);

  localparam int ACC_W = 8 + LOG2_PIXELS;
  localparam logic [LOG2_PIXELS-1:0] LAST_IDX = '1;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_NEXT,
    S_MEAN,
    S_DONE
  } state_t;

  typedef enum logic {
    PASS_SUM,
    PASS_BG
  } pass_t;

  state_t                 state;
  state_t                 state_nx;
  pass_t                  pass;
  logic [LOG2_PIXELS-1:0] idx;
  logic [7:0]             wait_cnt;
  logic [ACC_W-1:0]       acc_r;
  logic [ACC_W-1:0]       acc_g;
  logic [ACC_W-1:0]       acc_b;
  logic                   flag;
  logic                   timeout;
  logic                   last;

  assign flag    = (pass == PASS_SUM) ? pe.pe_sum_done : pe.pe_bg_done;
  assign timeout = !flag && (wait_cnt == WAIT_LAST);
  assign last    = (idx == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    pe.pe_ack = 1'b0;
    pix_addr  = idx;
    case (state)
      S_IDLE: begin
        if (Start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        Busy     = 1'b1;
        state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        Busy     = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        Busy = 1'b1;
        if (flag) begin
          state_nx = S_ACK;
        end else if (timeout) begin
          state_nx = S_DONE;
        end
      end
      S_ACK: begin
        Busy      = 1'b1;
        pe.pe_ack = 1'b1;
        if (!flag) state_nx = S_NEXT;
      end
      S_NEXT: begin
        Busy = 1'b1;
        if (last) begin
          state_nx = (pass == PASS_SUM) ? S_MEAN : S_DONE;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_MEAN: begin
        Busy     = 1'b1;
        state_nx = S_FETCH;
      end
      S_DONE: begin
        Done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Start pulses are registered together with pe_*_in so the pe samples
  // the new pixel on the same edge it sees its start request.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pass               <= PASS_SUM;
      idx                <= '0;
      wait_cnt           <= '0;
      acc_r              <= '0;
      acc_g              <= '0;
      acc_b              <= '0;
      Error              <= 1'b0;
      out_we             <= 1'b0;
      out_addr           <= '0;
      out_r              <= '0;
      out_g              <= '0;
      out_b              <= '0;
      pe.pe_start_sum    <= 1'b0;
      pe.pe_start_bg     <= 1'b0;
      pe.pe_threshold    <= '0;
      pe.pe_desired_bg_r <= '0;
      pe.pe_desired_bg_g <= '0;
      pe.pe_desired_bg_b <= '0;
      pe.pe_red_in       <= '0;
      pe.pe_green_in     <= '0;
      pe.pe_blue_in      <= '0;
      pe.pe_red_exp      <= '0;
      pe.pe_green_exp    <= '0;
      pe.pe_blue_exp     <= '0;
    end else begin
      pe.pe_start_sum <= 1'b0;
      pe.pe_start_bg  <= 1'b0;
      out_we          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            pe.pe_threshold    <= threshold;
            pe.pe_desired_bg_r <= desired_bg_r;
            pe.pe_desired_bg_g <= desired_bg_g;
            pe.pe_desired_bg_b <= desired_bg_b;
            acc_r              <= '0;
            acc_g              <= '0;
            acc_b              <= '0;
            idx                <= '0;
            Error              <= 1'b0;
            pass               <= PASS_SUM;
          end
        end
        S_ISSUE: begin
          pe.pe_red_in   <= pix_r;
          pe.pe_green_in <= pix_g;
          pe.pe_blue_in  <= pix_b;
          wait_cnt       <= '0;
          if (pass == PASS_SUM) begin
            pe.pe_start_sum <= 1'b1;
          end else begin
            pe.pe_start_bg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flag) begin
            if (pass == PASS_SUM) begin
              acc_r <= acc_r + ACC_W'(pe.pe_red_sum);
              acc_g <= acc_g + ACC_W'(pe.pe_green_sum);
              acc_b <= acc_b + ACC_W'(pe.pe_blue_sum);
            end else begin
              out_we   <= 1'b1;
              out_addr <= idx;
              out_r    <= pe.pe_red_out;
              out_g    <= pe.pe_green_out;
              out_b    <= pe.pe_blue_out;
            end
          end else if (timeout) begin
            Error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_NEXT: begin
          idx <= last ? '0 : idx + 1'b1;
        end
        S_MEAN: begin
          pe.pe_red_exp   <= 8'(acc_r >> LOG2_PIXELS);
          pe.pe_green_exp <= 8'(acc_g >> LOG2_PIXELS);
          pe.pe_blue_exp  <= 8'(acc_b >> LOG2_PIXELS);
          pass            <= PASS_BG;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_frame_sequencer.sv
// tb/tb_pe_frame_sequencer.sv - bench for pe_frame_sequencer with behavioural pe and buffers
// The pe and buffer models respond on the falling edge; the reference computes frame results directly.
module tb_pe_frame_sequencer;
  localparam int L  = 2;
  localparam int NP = 4;
  localparam int WL = 255;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [7:0]   threshold = '0;
  logic [7:0]   desired_bg_r = '0, desired_bg_g = '0, desired_bg_b = '0;
  logic         Busy, Done, Error;
  logic [L-1:0] pix_addr, out_addr;
  logic [7:0]   pix_r, pix_g, pix_b;
  logic         out_we;
  logic [7:0]   out_r, out_g, out_b;

  pe_frame_sequencer_if pif ();

  pe_frame_sequencer #(.LOG2_PIXELS(L), .WAIT_LIMIT(WL)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .threshold(threshold),
    .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
    .Busy(Busy), .Done(Done), .Error(Error), .pix_addr(pix_addr),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .out_we(out_we), .out_addr(out_addr),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .pe(pif)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [NP];
  logic [31:0] wq [$];
  int done_cnt, ack_cnt, bgs_cnt, ss_first, done_cyc, cyc;
  int sum_lat, bg_lat, bg_hold;
  bit never_sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] bg_fn(input logic [23:0] p, input logic [23:0] e,
                                        input logic [7:0] t, input logic [23:0] bg);
    bit near;
    int d;
    near = 1'b1;
    for (int c = 0; c < 3; c++) begin
      d = int'(p[c*8 +: 8]) - int'(e[c*8 +: 8]);
      if (d < 0) d = -d;
      if (d > int'(t)) near = 1'b0;
    end
    return near ? bg : p;
  endfunction

  function automatic logic [23:0] mean_of(input logic [NP-1:0][23:0] px);
    int s [3];
    logic [23:0] m;
    for (int c = 0; c < 3; c++) s[c] = 0;
    for (int i = 0; i < NP; i++)
      for (int c = 0; c < 3; c++) s[c] += int'(px[i][c*8 +: 8]);
    for (int c = 0; c < 3; c++) m[c*8 +: 8] = 8'(s[c] / NP);
    return m;
  endfunction

  // Behavioural pe, synchronous-read pixel buffer and output-side monitors.
  initial begin
    int s_wait, b_wait, b_left;
    bit s_pend, b_pend;
    logic [L-1:0] a_prev;
    s_pend = 0; b_pend = 0; s_wait = 0; b_wait = 0; b_left = 0; a_prev = '0; cyc = 0;
    pif.pe_sum_done = 0; pif.pe_bg_done = 0;
    {pif.pe_red_sum, pif.pe_green_sum, pif.pe_blue_sum} = '0;
    {pif.pe_red_out, pif.pe_green_out, pif.pe_blue_out} = '0;
    {pix_r, pix_g, pix_b} = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (out_we) wq.push_back(32'({out_addr, out_r, out_g, out_b}));
      if (Done) begin done_cnt++; done_cyc = cyc; end
      if (pif.pe_ack) ack_cnt++;
      if (pif.pe_start_sum && ss_first < 0) ss_first = cyc;
      if (pif.pe_start_bg) bgs_cnt++;
      {pix_r, pix_g, pix_b} = mem[a_prev];
      a_prev = pix_addr;
      if (!Reset) begin
        s_pend = 0; b_pend = 0;
        pif.pe_sum_done = 0; pif.pe_bg_done = 0;
      end else begin
        if (pif.pe_start_sum) begin
          s_pend = 1; s_wait = sum_lat;
          {pif.pe_red_sum, pif.pe_green_sum, pif.pe_blue_sum} =
            {pif.pe_red_in, pif.pe_green_in, pif.pe_blue_in};
        end
        if (pif.pe_sum_done) begin
          if (pif.pe_ack) pif.pe_sum_done = 0;
        end else if (s_pend) begin
          if (s_wait == 0) begin pif.pe_sum_done = !never_sum; s_pend = 0; end
          else s_wait--;
        end
        if (pif.pe_start_bg) begin
          b_pend = 1; b_wait = bg_lat;
          {pif.pe_red_out, pif.pe_green_out, pif.pe_blue_out} =
            bg_fn({pif.pe_red_in, pif.pe_green_in, pif.pe_blue_in},
                  {pif.pe_red_exp, pif.pe_green_exp, pif.pe_blue_exp}, pif.pe_threshold,
                  {pif.pe_desired_bg_r, pif.pe_desired_bg_g, pif.pe_desired_bg_b});
        end
        if (pif.pe_bg_done) begin
          if (pif.pe_ack) begin
            if (b_left == 0) pif.pe_bg_done = 0;
            else b_left--;
          end
        end else if (b_pend) begin
          if (b_wait == 0) begin pif.pe_bg_done = 1; b_pend = 0; b_left = bg_hold; end
          else b_wait--;
        end
      end
    end
  end

  typedef struct {
    logic [NP-1:0][23:0] px;
    logic [7:0]          thr;
    logic [23:0]         bg;
    int                  sum_lat;
    int                  bg_lat;
    int                  bg_hold;
    logic [23:0]         mean;
  } vec_t;

  vec_t vt [4];

  task automatic run_frame(input logic [NP-1:0][23:0] px, input logic [7:0] thr,
                           input logic [23:0] bg, input int mid_start,
                           output bit busy_a, output bit err_a);
    int n;
    for (int i = 0; i < NP; i++) mem[i] = px[i];
    wq.delete(); done_cnt = 0; ack_cnt = 0; bgs_cnt = 0; ss_first = -1;
    threshold = thr;
    {desired_bg_r, desired_bg_g, desired_bg_b} = bg;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    busy_a = Busy; err_a = Error;
    threshold = 8'($urandom);
    {desired_bg_r, desired_bg_g, desired_bg_b} = 24'($urandom);
    n = 0;
    while (!Done && n < 3000) begin
      @(negedge Clk);
      n++;
      Start = (n == mid_start);
    end
    Start = 1'b0;
    check("done_within_budget", 64'(n < 3000), 64'd1);
    @(negedge Clk);
  endtask

  task automatic check_frame(input string tag, input logic [NP-1:0][23:0] px,
                             input logic [7:0] thr, input logic [23:0] bg,
                             input logic [23:0] mean, input int hold);
    check($sformatf("%s_mean", tag), 64'({pif.pe_red_exp, pif.pe_green_exp, pif.pe_blue_exp}), 64'(mean));
    check($sformatf("%s_nwrites", tag), 64'(wq.size()), 64'(NP));
    for (int i = 0; i < NP; i++)
      if (i < wq.size())
        check($sformatf("%s_write%0d", tag, i), 64'(wq[i]),
              64'({2'(i), bg_fn(px[i], mean, thr, bg)}));
    check($sformatf("%s_done_once", tag), 64'(done_cnt), 64'd1);
    check($sformatf("%s_error", tag), 64'(Error), 64'd0);
    check($sformatf("%s_idle", tag), 64'(Busy), 64'd0);
    check($sformatf("%s_ack_cycles", tag), 64'(ack_cnt), 64'(NP + NP * (1 + hold)));
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s_status", tag), 64'({Busy, Done, Error, out_we}), 64'd0);
    check($sformatf("%s_addrs", tag), 64'({pix_addr, out_addr}), 64'd0);
    check($sformatf("%s_out", tag), 64'({out_r, out_g, out_b}), 64'd0);
    check($sformatf("%s_pe_ctl", tag), 64'({pif.pe_start_sum, pif.pe_start_bg, pif.pe_ack}), 64'd0);
    check($sformatf("%s_pe_in", tag), 64'({pif.pe_red_in, pif.pe_green_in, pif.pe_blue_in}), 64'd0);
    check($sformatf("%s_pe_exp", tag), 64'({pif.pe_red_exp, pif.pe_green_exp, pif.pe_blue_exp}), 64'd0);
  endtask

  initial begin
    bit busy_a, err_a;
    int n, dc;
    logic [NP-1:0][23:0] px;
    logic [23:0] base, bg;
    logic [7:0] thr;

    vt[0] = '{px: {NP{24'h3D85C6}}, thr: 8'd30, bg: 24'h0A0A0A,
              sum_lat: 0, bg_lat: 0, bg_hold: 0, mean: 24'h3D85C6};
    vt[1] = '{px: {24'h040000, 24'h020000, 24'h010000, 24'h000000}, thr: 8'd0, bg: 24'h323C46,
              sum_lat: 1, bg_lat: 0, bg_hold: 0, mean: 24'h010000};
    vt[2] = '{px: {NP{24'hFF0000}}, thr: 8'd0, bg: 24'h010203,
              sum_lat: 0, bg_lat: 1, bg_hold: 0, mean: 24'hFF0000};
    vt[3] = '{px: {24'h0C1C2C, 24'h808080, 24'h142434, 24'h102030}, thr: 8'd40, bg: 24'hAABBCC,
              sum_lat: 1, bg_lat: 2, bg_hold: 3, mean: 24'h2C3844};
    sum_lat = 0; bg_lat = 0; bg_hold = 0; never_sum = 0;
    for (int i = 0; i < NP; i++) mem[i] = '0;

    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_vals("reset");
    Reset = 1'b1;
    @(negedge Clk);

    for (int v = 0; v < 4; v++) begin
      sum_lat = vt[v].sum_lat; bg_lat = vt[v].bg_lat; bg_hold = vt[v].bg_hold;
      run_frame(vt[v].px, vt[v].thr, vt[v].bg, 0, busy_a, err_a);
      check($sformatf("vec%0d_busy_after_start", v), 64'(busy_a), 64'd1);
      check_frame($sformatf("vec%0d", v), vt[v].px, vt[v].thr, vt[v].bg, vt[v].mean, vt[v].bg_hold);
    end

    for (int r = 0; r < 6; r++) begin
      base = 24'($urandom);
      for (int i = 0; i < NP; i++)
        for (int c = 0; c < 3; c++)
          px[i][c*8 +: 8] = 8'(base[c*8 +: 8] + 8'($urandom_range(0, 24)));
      thr = 8'($urandom_range(0, 40));
      bg = 24'($urandom);
      sum_lat = $urandom_range(0, 3); bg_lat = $urandom_range(0, 3); bg_hold = $urandom_range(0, 2);
      run_frame(px, thr, bg, 0, busy_a, err_a);
      check_frame($sformatf("rand%0d", r), px, thr, bg, mean_of(px), bg_hold);
    end

    never_sum = 1; sum_lat = 0; bg_hold = 0;
    run_frame(vt[0].px, 8'd30, 24'h0A0A0A, 0, busy_a, err_a);
    check("timeout_error", 64'(Error), 64'd1);
    check("timeout_done_once", 64'(done_cnt), 64'd1);
    check("timeout_no_ack", 64'(ack_cnt), 64'd0);
    check("timeout_no_write", 64'(wq.size()), 64'd0);
    check("timeout_latency_ok", 64'((done_cyc - ss_first) >= WL && (done_cyc - ss_first) <= WL + 2), 64'd1);
    never_sum = 0;
    repeat (5) @(negedge Clk);
    check("error_sticky_idle", 64'(Error), 64'd1);

    sum_lat = 1; bg_lat = 1; bg_hold = 1;
    run_frame(vt[3].px, vt[3].thr, vt[3].bg, 10, busy_a, err_a);
    check("restart_error_cleared", 64'(err_a), 64'd0);
    check_frame("midstart", vt[3].px, vt[3].thr, vt[3].bg, vt[3].mean, 1);

    sum_lat = 0; bg_lat = 1; bg_hold = 0;
    for (int i = 0; i < NP; i++) mem[i] = vt[3].px[i];
    wq.delete(); done_cnt = 0; ack_cnt = 0; bgs_cnt = 0;
    threshold = vt[3].thr;
    {desired_bg_r, desired_bg_g, desired_bg_b} = vt[3].bg;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    n = 0;
    while (bgs_cnt < 3 && n < 2000) begin @(negedge Clk); n++; end
    check("reach_bg_pixel2", 64'(bgs_cnt), 64'd3);
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_vals("midreset");
    dc = done_cnt;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("midreset_no_done", 64'(done_cnt), 64'(dc));
    run_frame(vt[3].px, vt[3].thr, vt[3].bg, 0, busy_a, err_a);
    check_frame("after_reset", vt[3].px, vt[3].thr, vt[3].bg, vt[3].mean, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
